// File: rtl/screen_map.sv
// Viewport mapping: scales projected float (x, y), converts to integer pixels, centres, clamps.
// Latency: 2*MUL_LATENCY+3 cycles from valid_in to valid_out; one point in flight.
// Backpressure: none; valid_in is dropped while a point is in flight (busy_out high).
module multiplier #(
    parameter int LATENCY = 4
) (
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata
);
    logic [47:0]        prod;
    logic signed [9:0]  exp_c;
    logic [22:0]        frac;
    logic [23:0]        rnd;
    logic               grd, stk, sgn;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]        res;
    logic [31:0]        dat_pipe [LATENCY];
    logic [LATENCY-1:0] vld_pipe;

    // Round-to-nearest-even on normals; denormals are flushed to zero.
    always_comb begin
        prod   = 48'({1'b1, s_axis_a_tdata[22:0]}) * 48'({1'b1, s_axis_b_tdata[22:0]});
        exp_c  = $signed({2'b00, s_axis_a_tdata[30:23]}) + $signed({2'b00, s_axis_b_tdata[30:23]}) - 10'sd127;
        if (prod[47]) begin
            frac  = prod[46:24];
            grd   = prod[23];
            stk   = |prod[22:0];
            exp_c = exp_c + 10'sd1;
        end else begin
            frac  = prod[45:23];
            grd   = prod[22];
            stk   = |prod[21:0];
        end
        rnd = {1'b0, frac} + {23'd0, grd & (stk | frac[0])};
        if (rnd[23]) exp_c = exp_c + 10'sd1;
        sgn    = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
        a_zero = (s_axis_a_tdata[30:23] == 8'd0);
        b_zero = (s_axis_b_tdata[30:23] == 8'd0);
        a_inf  = (s_axis_a_tdata[30:23] == 8'hff) && (s_axis_a_tdata[22:0] == 23'd0);
        b_inf  = (s_axis_b_tdata[30:23] == 8'hff) && (s_axis_b_tdata[22:0] == 23'd0);
        a_nan  = (s_axis_a_tdata[30:23] == 8'hff) && (s_axis_a_tdata[22:0] != 23'd0);
        b_nan  = (s_axis_b_tdata[30:23] == 8'hff) && (s_axis_b_tdata[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = 32'h7fc00000;
        else if (a_inf || b_inf || exp_c >= 10'sd255)
            res = {sgn, 8'hff, 23'd0};
        else if (a_zero || b_zero || exp_c <= 10'sd0)
            res = {sgn, 31'd0};
        else
            res = {sgn, exp_c[7:0], rnd[22:0]};
    end

    always_ff @(posedge aclk) begin
        dat_pipe[0] <= res;
        vld_pipe[0] <= s_axis_a_tvalid & s_axis_b_tvalid;
        for (int i = 1; i < LATENCY; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign m_axis_result_tvalid = vld_pipe[LATENCY-1];
    assign m_axis_result_tdata  = dat_pipe[LATENCY-1];
endmodule

module screen_map #(
    parameter logic [31:0] SCALE       = 32'h42c80000,
    parameter int          H_RES       = 1280,
    parameter int          V_RES       = 720,
    parameter int          X_CENTER    = 640,
    parameter int          Y_CENTER    = 360,
    parameter int          MUL_LATENCY = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] coor_in [1:0],
    input  logic        valid_in,
    output logic        busy_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        on_screen,
    output logic        valid_out
);
    typedef enum logic [2:0] {IDLE, MULX, MULY, CONV, OUT} state_t;

    state_t             state, next_state;
    logic [31:0]        x_lat, y_lat, sx, sy;
    logic signed [15:0] ix, iy;
    logic               nan;
    logic               mul_vld, res_vld;
    logic [31:0]        mul_dat, res_dat;
    logic signed [17:0] px, py;
    logic               nan_x, nan_y;

    // Returns {nan, int16}: round half away from zero, saturating.
    function automatic logic [16:0] f2i(input logic [31:0] v);
        logic [7:0]  e;
        logic [23:0] m, q;
        logic [4:0]  sh;
        logic [16:0] mag;
        e   = v[30:23];
        m   = {1'b1, v[22:0]};
        sh  = 5'd0;
        q   = 24'd0;
        mag = 17'd0;
        if (e == 8'hff && v[22:0] != 23'd0) return {1'b1, 16'd0};
        if (e < 8'd126) return 17'd0;
        if (e > 8'd141) return {1'b0, v[31] ? 16'h8000 : 16'h7fff};
        sh  = 5'(8'd150 - e);
        q   = m >> sh;
        mag = {1'b0, q[15:0]} + {16'd0, m[sh - 5'd1]};
        if (v[31]) return {1'b0, 16'(17'd0 - mag)};
        return {1'b0, (mag > 17'd32767) ? 16'h7fff : mag[15:0]};
    endfunction

    multiplier #(.LATENCY(MUL_LATENCY)) u_mul (
        .aclk                 (clk_in),
        .s_axis_a_tvalid      (mul_vld),
        .s_axis_a_tdata       (mul_dat),
        .s_axis_b_tvalid      (mul_vld),
        .s_axis_b_tdata       (SCALE),
        .m_axis_result_tvalid (res_vld),
        .m_axis_result_tdata  (res_dat)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid_in) next_state = MULX;
            MULX:    if (res_vld)  next_state = MULY;
            MULY:    if (res_vld)  next_state = CONV;
            CONV:    next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands go straight to the multiplier so the issue cycle costs no latency.
    always_comb begin
        mul_vld = 1'b0;
        mul_dat = x_lat;
        if (!rst_in) begin
            if (state == IDLE && valid_in) begin
                mul_vld = 1'b1;
                mul_dat = coor_in[1];
            end else if (state == MULX && res_vld) begin
                mul_vld = 1'b1;
                mul_dat = y_lat;
            end
        end
    end

    assign px       = 18'(X_CENTER) + 18'(ix);
    assign py       = 18'(Y_CENTER) - 18'(iy);
    assign busy_out = (state != IDLE) || valid_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            on_screen <= 1'b0;
            nan       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: if (valid_in) begin
                    x_lat <= coor_in[1];
                    y_lat <= coor_in[0];
                end
                MULX: if (res_vld) sx <= res_dat;
                MULY: if (res_vld) sy <= res_dat;
                CONV: begin
                    {nan_x, ix} <= f2i(sx);
                    {nan_y, iy} <= f2i(sy);
                    nan         <= f2i(sx) >> 16 != 17'd0 || f2i(sy) >> 16 != 17'd0;
                end
                OUT: begin
                    valid_out <= 1'b1;
                    on_screen <= !nan && px >= 0 && px < 18'(H_RES) && py >= 0 && py < 18'(V_RES);
                    if (nan) begin
                        x_out <= 11'(X_CENTER);
                        y_out <= 10'(Y_CENTER);
                    end else begin
                        x_out <= (px < 0) ? 11'd0 : (px > 18'(H_RES - 1)) ? 11'(H_RES - 1) : px[10:0];
                        y_out <= (py < 0) ? 10'd0 : (py > 18'(V_RES - 1)) ? 10'(V_RES - 1) : py[9:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
